// File: rtl/seq_display_out.sv
// ---------------------------------------------------------------------------
// seq_display_out
//   Converts a binary value, which may be signed, into active-low 7-segment
//   digit codes. The conversion is sequential: one double-dabble step per
//   clock. All outputs are registered. They change only on the UPDATE edge
//   and hold their value between updates.
//
// Parameters
//   DATA_W   width of Dado (8..32)
//   DIGITS   number of magnitude digits driven (1..8)
//   LED_W    width of LEDs (LED_W <= DATA_W)
//   BLANK_LZ 1 = blank leading zero digits (digit 0 is always shown)
//
// Ports
//   CLK          clock, rising edge
//   Reset        synchronous, active-high
//   Dado         value to display
//   OutWrite     write strobe, sampled every edge
//   Signed       1 = Dado is two's complement (sampled with OutWrite)
//   Display      digit i at [7i+6:7i], digit 0 = units, bit6=a .. bit0=g
//   DisplaySign  minus (1111110) or blank (1111111)
//   LEDs         low LED_W bits of the displayed Dado
//   Busy         conversion in progress
//   Done         one-cycle pulse on the cycle the outputs update
//   Overflow     displayed value does not fit in DIGITS digits
//   dbg_state_o  current FSM state (0 IDLE, 1 SHIFT, 2 UPDATE)
//
// Write handshake: a write is any edge where OutWrite=1. A write seen in
// IDLE with no pending value starts a conversion at once. A write seen
// while a conversion runs, or during UPDATE, goes into a 1-deep pending
// slot; a later write overwrites the slot. A pending value starts its
// conversion on the edge after UPDATE. No write is ever refused.
// ---------------------------------------------------------------------------
module seq_display_out #(
  parameter int DATA_W   = 32,
  parameter int DIGITS   = 4,
  parameter int LED_W    = 11,
  parameter int BLANK_LZ = 1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   Dado,
  input  logic                OutWrite,
  input  logic                Signed,
  output logic [7*DIGITS-1:0] Display,
  output logic [6:0]          DisplaySign,
  output logic [LED_W-1:0]    LEDs,
  output logic                Busy,
  output logic                Done,
  output logic                Overflow,
  output logic [1:0]          dbg_state_o
);

  // Internal BCD digit count. It covers the largest DATA_W-bit magnitude.
  localparam int NB = (DATA_W + 2) / 3 + 1;
  // Working width for formatting. It covers both the BCD digits and the
  // displayed digits.
  localparam int NX = (NB > DIGITS) ? NB : DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic                nz_q, nz_d;
  logic [DATA_W-1:0]   mag_q, mag_d;
  logic [DATA_W-1:0]   dado_q, dado_d;
  logic [4*NB-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pend_v_q, pend_v_d;
  logic [DATA_W-1:0]   pend_dado_q, pend_dado_d;
  logic                pend_sgn_q, pend_sgn_d;
  logic [7*DIGITS-1:0] disp_q, disp_d;
  logic [6:0]          dsign_q, dsign_d;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  // Signals used only inside the combinational process.
  logic [4*NB-1:0]     bcd_adj;
  logic [4*NX-1:0]     bcd_ext;
  logic [7*DIGITS-1:0] disp_c;
  logic                ovf_c;
  logic                lead;
  logic [3:0]          dig;
  logic                start_c;
  logic [DATA_W-1:0]   src_dado;
  logic                src_sgn;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    nz_d        = nz_q;
    mag_d       = mag_q;
    dado_d      = dado_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    pend_v_d    = pend_v_q;
    pend_dado_d = pend_dado_q;
    pend_sgn_d  = pend_sgn_q;
    disp_d      = disp_q;
    dsign_d     = dsign_q;
    leds_d      = leds_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;

    // Double-dabble correction: add 3 to every BCD digit that is >= 5.
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    // Format the finished BCD value. bcd_ext pads with zeros up to NX
    // digits, so DIGITS may exceed the BCD width.
    bcd_ext = '0;
    bcd_ext[4*NB-1:0] = bcd_q;
    ovf_c = 1'b0;
    for (int i = DIGITS; i < NX; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) ovf_c = 1'b1;
    end
    disp_c = '0;
    lead   = 1'b1;
    dig    = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig = bcd_ext[4*i +: 4];
      if (dig != 4'd0) lead = 1'b0;
      if (ovf_c) disp_c[7*i +: 7] = SEG_DASH;
      else if ((BLANK_LZ != 0) && lead && (i != 0)) disp_c[7*i +: 7] = SEG_BLANK;
      else disp_c[7*i +: 7] = seg7(dig);
    end

    // Choose the source of a new conversion. A pending value goes first.
    start_c  = 1'b0;
    src_dado = Dado;
    src_sgn  = Signed;
    if (state_q == IDLE) begin
      if (pend_v_q) begin
        start_c  = 1'b1;
        src_dado = pend_dado_q;
        src_sgn  = pend_sgn_q;
        pend_v_d = 1'b0;
      end else if (OutWrite) begin
        start_c = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_c) begin
          sign_d  = src_sgn & src_dado[DATA_W-1];
          mag_d   = sign_d ? (~src_dado + DATA_W'(1)) : src_dado;
          nz_d    = |src_dado;
          dado_d  = src_dado;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[4*NB-2:0], mag_q[DATA_W-1]};
        mag_d = {mag_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        disp_d  = disp_c;
        ovf_d   = ovf_c;
        dsign_d = (sign_q && nz_q) ? SEG_DASH : SEG_BLANK;
        leds_d  = dado_q[LED_W-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A write that does not start a conversion at once goes to the slot.
    if (OutWrite && !(state_q == IDLE && !pend_v_q)) begin
      pend_v_d    = 1'b1;
      pend_dado_d = Dado;
      pend_sgn_d  = Signed;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      nz_q        <= 1'b0;
      mag_q       <= '0;
      dado_q      <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_dado_q <= '0;
      pend_sgn_q  <= 1'b0;
      disp_q      <= {DIGITS{SEG_BLANK}};
      dsign_q     <= SEG_BLANK;
      leds_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      nz_q        <= nz_d;
      mag_q       <= mag_d;
      dado_q      <= dado_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      pend_v_q    <= pend_v_d;
      pend_dado_q <= pend_dado_d;
      pend_sgn_q  <= pend_sgn_d;
      disp_q      <= disp_d;
      dsign_q     <= dsign_d;
      leds_q      <= leds_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign Display     = disp_q;
  assign DisplaySign = dsign_q;
  assign LEDs        = leds_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_display_out.sv
// ---------------------------------------------------------------------------
// tb_seq_display_out
//   Directed bench for seq_display_out with DATA_W=32, DIGITS=4, LED_W=11
//   and BLANK_LZ=1. Expected values are hand-computed segment codes.
// ---------------------------------------------------------------------------
module tb_seq_display_out;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b1111110;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dado;
  logic        out_write;
  logic        sgn;
  logic [27:0] display;
  logic [6:0]  display_sign;
  logic [10:0] leds;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [1:0]  dbg_state;

  int passes = 0;
  int checks = 0;
  int n;
  int dones;

  always #5 clk = ~clk;

  seq_display_out #(.DATA_W(32), .DIGITS(4), .LED_W(11), .BLANK_LZ(1)) dut (
    .CLK(clk), .Reset(rst), .Dado(dado), .OutWrite(out_write), .Signed(sgn),
    .Display(display), .DisplaySign(display_sign), .LEDs(leds), .Busy(busy),
    .Done(done), .Overflow(overflow), .dbg_state_o(dbg_state)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] d, input logic s);
    dado = d;
    sgn = s;
    out_write = 1'b1;
    tick();
    out_write = 1'b0;
  endtask

  // Counts edges until Done is seen (100 edges at most). Also notes whether
  // Busy and Done were ever high together.
  task automatic wait_done(input string tag, output int cnt);
    logic both;
    both = 1'b0;
    cnt = 0;
    while (cnt < 100) begin
      tick();
      cnt++;
      if (busy && done) both = 1'b1;
      if (done) break;
    end
    check({tag, "_busy_done_excl"}, both, 1'b0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) cnt++;
    end
  endtask

  task automatic check_out(input string tag, input logic [27:0] e_disp, input logic [6:0] e_sign,
                           input logic [10:0] e_leds, input logic e_ovf);
    check({tag, "_display"}, display, e_disp);
    check({tag, "_sign"}, display_sign, e_sign);
    check({tag, "_leds"}, leds, e_leds);
    check({tag, "_ovf"}, overflow, e_ovf);
    check({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    dado = 32'd1234;
    sgn = 1'b0;
    out_write = 1'b1;  // reset must win over a simultaneous write
    tick();
    tick();
    out_write = 1'b0;
    check("rst_display", display, {4{BL}});
    check("rst_sign", display_sign, BL);
    check("rst_leds", leds, 11'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    // 1234 unsigned
    do_write(32'd1234, 1'b0);
    check("t1234_busy", busy, 1'b1);
    check("t1234_state", dbg_state, 2'd1);
    wait_done("t1234", n);
    check("t1234_latency", n, 33);
    check_out("t1234", {S1, S2, S3, S4}, BL, 11'd1234, 1'b0);
    tick();
    check("t1234_done_pulse", done, 1'b0);
    check("t1234_busy_after", busy, 1'b0);
    check("t1234_hold", display, {S1, S2, S3, S4});

    // -123
    do_write(32'hFFFFFF85, 1'b1);
    wait_done("tneg", n);
    check("tneg_latency", n, 33);
    check_out("tneg", {BL, S1, S2, S3}, DS, 11'h785, 1'b0);

    // 10000 overflows four digits
    do_write(32'd10000, 1'b0);
    wait_done("t10000", n);
    check_out("t10000", {4{DS}}, BL, 11'd10000 & 11'h7FF, 1'b1);

    // most negative value
    do_write(32'h80000000, 1'b1);
    wait_done("tmin", n);
    check_out("tmin", {4{DS}}, DS, 11'd0, 1'b1);

    // zero
    do_write(32'd0, 1'b1);
    wait_done("tzero", n);
    check_out("tzero", {BL, BL, BL, S0}, BL, 11'd0, 1'b0);

    // largest value that fits
    do_write(32'd9999, 1'b0);
    wait_done("t9999", n);
    check_out("t9999", {S9, S9, S9, S9}, BL, 11'h70F, 1'b0);

    // inner zeros shown, positive signed value
    do_write(32'd1000, 1'b1);
    wait_done("t1000", n);
    check_out("t1000", {S1, S0, S0, S0}, BL, 11'h3E8, 1'b0);

    // same bits as -123, read as unsigned
    do_write(32'hFFFFFF85, 1'b0);
    wait_done("tbig", n);
    check_out("tbig", {4{DS}}, BL, 11'h785, 1'b1);

    // pending slot: 5, then 7 and 9 while busy
    do_write(32'd5, 1'b0);
    tick();
    do_write(32'd7, 1'b0);
    do_write(32'd9, 1'b0);
    wait_done("tpend5", n);
    check("tpend5_latency", n, 30);
    check_out("tpend5", {BL, BL, BL, S5}, BL, 11'd5, 1'b0);
    wait_done("tpend9", n);
    check("tpend9_latency", n, 34);
    check_out("tpend9", {BL, BL, BL, S9}, BL, 11'd9, 1'b0);
    count_dones(40, dones);
    check("tpend_no_extra", dones, 0);

    // write during the UPDATE cycle
    do_write(32'd3, 1'b0);
    repeat (32) tick();
    check("tupd_state", dbg_state, 2'd2);
    check("tupd_busy", busy, 1'b1);
    do_write(32'd8, 1'b0);
    check_out("tupd3", {BL, BL, BL, S3}, BL, 11'd3, 1'b0);
    wait_done("tupd8", n);
    check("tupd8_latency", n, 34);
    check_out("tupd8", {BL, BL, BL, S8}, BL, 11'd8, 1'b0);

    // reset at E10 aborts the conversion
    do_write(32'd1234, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("tabort_display", display, {4{BL}});
    check("tabort_sign", display_sign, BL);
    check("tabort_leds", leds, 11'd0);
    check("tabort_busy", busy, 1'b0);
    check("tabort_done", done, 1'b0);
    check("tabort_ovf", overflow, 1'b0);
    check("tabort_state", dbg_state, 2'd0);
    count_dones(40, dones);
    check("tabort_no_done", dones, 0);
    do_write(32'd42, 1'b0);
    wait_done("tafter", n);
    check("tafter_latency", n, 33);
    check_out("tafter", {BL, BL, S4, S2}, BL, 11'd42, 1'b0);

    // Final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_display_out.md
SEQ_DISPLAY_OUT -- requirements
Module: seq_display_out

Interface
REQ-001 Parameter DATA_W, default 32: width of Dado (8..32).
REQ-002 Parameter DIGITS, default 4: number of magnitude digits driven (1..8).
REQ-003 Parameter LED_W, default 11: width of LEDs (LED_W <= DATA_W).
REQ-004 Parameter BLANK_LZ, default 1: blank leading zero digits when 1.
REQ-005 CLK  in  1  clock; all state changes on rising edge.
REQ-006 Reset  in  1  reset, synchronous, active-high.
REQ-007 Dado  in  DATA_W  value to display.
REQ-008 OutWrite  in  1  write strobe, sampled each edge.
REQ-009 Signed  in  1  1 = Dado is two's complement; sampled with OutWrite.
REQ-010 Display  out  7*DIGITS  digit i at [7i+6:7i], digit 0 = units; bit6=a..bit0=g, active-low.
REQ-011 DisplaySign  out  7  minus (1111110) or blank (1111111).
REQ-012 LEDs  out  LED_W  Dado[LED_W-1:0] of the displayed value.
REQ-013 Busy  out  1  conversion in progress.
REQ-014 Done  out  1  one-cycle pulse when outputs update.
REQ-015 Overflow  out  1  displayed value exceeds 10^DIGITS-1.

Function
REQ-016 FSM states IDLE, SHIFT, UPDATE; all outputs registered.
REQ-017 Edge E0 (IDLE, OutWrite=1): capture sign = Signed & Dado[DATA_W-1]; magnitude = sign ? two's-complement negation of all DATA_W bits : Dado; clear BCD and bit counter; go SHIFT; Busy=1.
REQ-018 Magnitude register is DATA_W bits unsigned; -2^(DATA_W-1) yields 2^(DATA_W-1).
REQ-019 SHIFT: one double-dabble step per edge (add 3 to every BCD digit >= 5, then shift left one bit, MSB of magnitude into BCD bit 0); internal BCD holds ceil(DATA_W/3)+1 digits.
REQ-020 After DATA_W steps (edge E_DATA_W) go UPDATE.
REQ-021 Edge E_DATA_W+1 (UPDATE): load Display, DisplaySign, LEDs, Overflow; Done=1 for exactly this cycle; Busy=0; go IDLE.
REQ-022 Latency OutWrite-to-display: DATA_W+1 edges after E0 (33 for DATA_W=32).
REQ-023 Digit codes 0..9: 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0000100; blank 1111111.
REQ-024 Overflow = any internal BCD digit at index >= DIGITS nonzero; then every Display digit = 1111110 (dash).
REQ-025 BLANK_LZ=1: zero digits above the most significant nonzero digit blank; digit 0 always shown.
REQ-026 DisplaySign = 1111110 when sign=1 and magnitude nonzero, else 1111111; shown on overflow too.
REQ-027 OutWrite=1 while Busy: Dado/Signed stored in 1-deep pending slot; later writes overwrite it.
REQ-028 Pending slot valid at UPDATE: next conversion starts on the following edge as if E0; slot cleared.
REQ-029 OutWrite=1 in UPDATE cycle: treated as pending write (REQ-027).
REQ-030 Outputs hold last value between updates; Done and Busy never high together.

Reset
REQ-031 Reset=1 at an edge: state IDLE, Display all 1111111, DisplaySign 1111111, LEDs 0, Busy 0, Done 0, Overflow 0, pending cleared, BCD/counter cleared.
REQ-032 Reset has priority over OutWrite at the same edge; mid-conversion reset aborts with no Done.

Verification (DATA_W=32, DIGITS=4, LED_W=11, BLANK_LZ=1)
REQ-033 Signed=0, Dado=1234 -> 33 edges later Display = 1001111,0010010,0000110,1001100 (digit3..0), DisplaySign blank, Overflow 0, Done one cycle, LEDs=1234.
REQ-034 Signed=1, Dado=32'hFFFFFF85 -> digit3 blank, digits 1,2,3; DisplaySign 1111110; LEDs=11'h785.
REQ-035 Signed=0, Dado=10000 -> Overflow 1, all digits 1111110; Signed=1, Dado=32'h80000000 -> Overflow 1, DisplaySign minus.
REQ-036 Dado=0 -> digit0 0000001, digits 3..1 blank, DisplaySign blank, Overflow 0.
REQ-037 Write 5, then 7 and 9 while Busy -> display 5 with Done, then 9 with second Done; 7 never shown.
REQ-038 Reset at E10 of a conversion -> next cycle all outputs blank/0, Busy 0, no Done pulse; a following write converts normally.
